// File: rtl/mem_pkg.sv
// Shared widths, block geometry and burst FSM encoding for multicycle_mem.
// The burst items are only referenced when MEM_BURST_EN is defined.
package mem_pkg;

  localparam int WORD_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int BLOCK_WORDS = 4;

  localparam logic [ADDR_W-1:0] BLOCK_ALIGN_MASK = 16'hFFF8;
  localparam logic [ADDR_W-1:0] WORD_ALIGN_MASK  = 16'hFFFE;
  localparam logic [ADDR_W-1:0] WORD_STRIDE      = 16'd2;
  localparam logic [1:0]        LAST_BEAT        = 2'(BLOCK_WORDS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_t;

  // Byte address of the 16-bit word containing a.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/mem_lat_pipe.sv
// Shift register of {valid, addr, data} used to give read data a fixed latency.
// Only the valid bits are reset so the payload flops can stay reset-free.
module mem_lat_pipe #(
  parameter int DEPTH = 3,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_valid = i_valid;
      assign o_addr  = i_addr;
      assign o_data  = i_data;
    end else begin : g_pipe
      logic [DEPTH-1:0] r_valid;
      logic [AW-1:0]    r_addr [DEPTH];
      logic [DW-1:0]    r_data [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= '0;
        end else begin
          r_valid[0] <= i_valid;
          for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        r_addr[0] <= i_addr;
        r_data[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) begin
          r_addr[i] <= r_addr[i-1];
          r_data[i] <= r_data[i-1];
        end
      end

      assign o_valid = r_valid[DEPTH-1];
      assign o_addr  = r_addr[DEPTH-1];
      assign o_data  = r_data[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/multicycle_mem.sv
// Pipelined single-port 16-bit word memory with fixed read latency, behind the I/D cache arbiter.
// Define MEM_BURST_EN to enable 4-word block reads driven by a small burst FSM.
module multicycle_mem
  import mem_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic              burst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] data_in,
  output logic              ready,
  output logic              data_valid,
  output logic [WORD_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_out
);

  localparam int MEM_WORDS = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] r_mem [MEM_WORDS];
  logic              r_ready;

  logic              w_accept;
  logic              w_accept_wr;
  logic              w_accept_rd;
  logic              w_issue_valid;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [WORD_W-1:0] w_issue_data;
  logic              w_pipe_valid;
  logic [ADDR_W-1:0] w_pipe_addr;
  logic [WORD_W-1:0] w_pipe_data;

  assign w_accept    = req & r_ready;
  assign w_accept_wr = w_accept & wr;
  assign w_accept_rd = w_accept & ~wr;

`ifdef MEM_BURST_EN
  burst_state_t      r_state;
  logic [1:0]        r_beat;
  logic [ADDR_W-1:0] r_burst_addr;
  logic              w_burst_start;

  assign w_burst_start = w_accept_rd & burst;

  // Word 0 of a block issues in the accept cycle; the FSM issues words 1..3 and holds ready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b0;
      r_beat       <= 2'd0;
      r_burst_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_burst_start) begin
            r_state      <= ST_BURST;
            r_ready      <= 1'b0;
            r_beat       <= 2'd1;
            r_burst_addr <= (addr & BLOCK_ALIGN_MASK) + WORD_STRIDE;
          end
        end
        ST_BURST: begin
          r_beat       <= r_beat + 2'd1;
          r_burst_addr <= r_burst_addr + WORD_STRIDE;
          if (r_beat == LAST_BEAT) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign w_issue_valid = w_accept_rd | (r_state == ST_BURST);
  assign w_issue_addr  = (r_state == ST_BURST) ? r_burst_addr :
                         w_burst_start         ? (addr & BLOCK_ALIGN_MASK) :
                                                 word_align(addr);
`else
  logic w_unused_burst;

  assign w_unused_burst = burst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
    end
  end

  assign w_issue_valid = w_accept_rd;
  assign w_issue_addr  = word_align(addr);
`endif

  // Upper address bits beyond DEPTH_LOG2 simply alias; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (w_accept_wr) begin
      r_mem[addr[DEPTH_LOG2:1]] <= data_in;
    end
  end

  assign w_issue_data = r_mem[w_issue_addr[DEPTH_LOG2:1]];

  mem_lat_pipe #(
    .DEPTH (LATENCY - 1),
    .AW    (ADDR_W),
    .DW    (WORD_W)
  ) u_lat_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_issue_valid),
    .i_addr  (w_issue_addr),
    .i_data  (w_issue_data),
    .o_valid (w_pipe_valid),
    .o_addr  (w_pipe_addr),
    .o_data  (w_pipe_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_valid <= 1'b0;
      data_out   <= '0;
      addr_out   <= '0;
    end else begin
      data_valid <= w_pipe_valid;
      if (w_pipe_valid) begin
        data_out <= w_pipe_data;
        addr_out <= w_pipe_addr;
      end
    end
  end

  assign ready = r_ready;

endmodule
